cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: entries per requester queue (power of two, >=2).
REQ-002 SHALL have port in_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port in_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_mispred  input  1  flush request from ROB.
REQ-005 SHALL have ports in_alu_valid, in_ls_valid  input  1 each  requester offers a result.
REQ-006 SHALL have ports in_alu_rob_index, in_ls_rob_index  input  ROB_IDX_SIZE each  destination ROB slot.
REQ-007 SHALL have ports in_alu_value, in_ls_value  input  GPR_SIZE each  result value.
REQ-008 SHALL have ports in_alu_set_nzcv, in_ls_set_nzcv  input  1 each; in_alu_nzcv, in_ls_nzcv  input  nzcv_t each.
REQ-009 SHALL have ports out_alu_ready, out_ls_ready  output  1 each  queue can accept this cycle.
REQ-010 SHALL have ports out_cdb_done  output  1; out_cdb_index  output  ROB_IDX_SIZE; out_cdb_value  output  GPR_SIZE; out_cdb_set_nzcv  output  1; out_cdb_nzcv  output  nzcv_t: registered broadcast to ROB and both reservation stations.

Function
REQ-011 SHALL hold one FIFO per requester; push when in_X_valid & out_X_ready at a rising edge.
REQ-012 SHALL drive out_X_ready = (count_X < FIFO_DEPTH), combinational from count only; a same-cycle pop SHALL NOT raise ready.
REQ-013 SHALL grant at most one queue head per cycle; grant pops that head at the same edge that loads it into the output registers.
REQ-014 SHALL present a result pushed at edge E on the out_cdb_* registers no earlier than edge E+1 (no input-to-output bypass); out_cdb_done SHALL be high for exactly one cycle per broadcast.
REQ-015 SHALL drive out_cdb_done low, with out_cdb_* data holding its last value, in any cycle without a grant.
REQ-016 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH inclusive.
REQ-017 SHALL allow simultaneous push and pop on the same queue; count stays unchanged.
REQ-018 SHALL, when in_mispred is high at an edge: empty both queues, discard that cycle's pushes, cancel that cycle's grant, and load out_cdb_done=0.
REQ-019 SHALL never broadcast the same entry twice nor drop an accepted entry absent in_mispred.

Reset
REQ-020 SHALL, while in_rst_n=0, force out_cdb_done=0, out_cdb_index=0, out_cdb_value=0, out_cdb_set_nzcv=0, out_cdb_nzcv=0, both counts/pointers=0, last_grant=LS.
REQ-021 SHALL drive out_alu_ready=out_ls_ready=1 immediately after reset deassertion (empty queues).
REQ-022 SHALL abandon any in-flight queue contents on reset assertion mid-operation; nothing is broadcast afterwards for them.

Configuration
REQ-023 SHALL implement round-robin arbitration when CDB_RR_EN is defined: if both heads valid, grant the requester not in last_grant; last_grant updates on every grant.
REQ-024 SHALL implement fixed priority when CDB_RR_EN is undefined: LS head always wins over ALU head; last_grant unused.
REQ-025 SHALL behave identically under both settings when only one queue is non-empty.

Structure
REQ-026 SHALL take nzcv_t, GPR_SIZE, ROB_IDX_SIZE and a new cdb_entry_t struct (rob_index, value, set_nzcv, nzcv) from data_structures.sv.
REQ-027 SHALL instantiate sub-module cdb_fifo (parameterised depth, cdb_entry_t payload, push/pop/flush, count out) twice.

Verification
REQ-028 Reset release then single ALU push (index 5, value 42) at edge 1 -> out_cdb_done=1, index 5, value 42 after edge 2; low after edge 3.
REQ-029 CDB_RR_EN defined, ALU and LS push together every cycle for 6 cycles -> broadcasts alternate ALU, LS, ALU... starting ALU; out_X_ready drops when count reaches 2; no entry lost.
REQ-030 CDB_RR_EN undefined, same stimulus -> all LS entries broadcast before any ALU entry; ALU ready stays low while its queue is full.
REQ-031 Fill ALU queue (indices 1,2), assert in_mispred with in_ls_valid=1 -> next cycle out_cdb_done=0, both ready=1, indices 1,2 and LS entry never broadcast.
REQ-032 Push LS with set_nzcv=1, nzcv=4'b0110 -> out_cdb_set_nzcv=1, out_cdb_nzcv=4'b0110 on broadcast cycle.
REQ-033 Assert in_rst_n=0 asynchronously mid-stream with 2 queued entries -> outputs zero before next clock edge; no later broadcasts of those entries.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared result-bus types for the CDB arbiter and its per-requester queues.
package cdb_arbiter_pkg;

  localparam int GPR_SIZE     = 32;
  localparam int ROB_IDX_SIZE = 4;

  typedef logic [3:0] nzcv_t;

  typedef struct packed {
    logic [ROB_IDX_SIZE-1:0] rob_index;
    logic [GPR_SIZE-1:0]     value;
    logic                    set_nzcv;
    nzcv_t                   nzcv;
  } cdb_entry_t;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LS  = 1'b1
  } grant_e;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// cdb_fifo: power-of-two circular queue of cdb_entry_t with synchronous flush.
// Push/pop are qualified by the caller (no push when full, no pop when empty).
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  cdb_entry_t               i_data,
  output cdb_entry_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  cdb_entry_t          r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW:0]         r_count;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LS results and broadcasts one per cycle.
// Define CDB_RR_EN for round-robin arbitration; default is fixed LS-over-ALU priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_mispred,
  input  logic                    in_alu_valid,
  input  logic                    in_ls_valid,
  input  logic [ROB_IDX_SIZE-1:0] in_alu_rob_index,
  input  logic [ROB_IDX_SIZE-1:0] in_ls_rob_index,
  input  logic [GPR_SIZE-1:0]     in_alu_value,
  input  logic [GPR_SIZE-1:0]     in_ls_value,
  input  logic                    in_alu_set_nzcv,
  input  logic                    in_ls_set_nzcv,
  input  nzcv_t                   in_alu_nzcv,
  input  nzcv_t                   in_ls_nzcv,
  output logic                    out_alu_ready,
  output logic                    out_ls_ready,
  output logic                    out_cdb_done,
  output logic [ROB_IDX_SIZE-1:0] out_cdb_index,
  output logic [GPR_SIZE-1:0]     out_cdb_value,
  output logic                    out_cdb_set_nzcv,
  output nzcv_t                   out_cdb_nzcv
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [CW-1:0] w_alu_count;
  logic [CW-1:0] w_ls_count;
  cdb_entry_t    w_alu_in;
  cdb_entry_t    w_ls_in;
  cdb_entry_t    w_alu_head;
  cdb_entry_t    w_ls_head;
  logic          w_alu_push;
  logic          w_ls_push;
  logic          w_alu_pop;
  logic          w_ls_pop;
  logic          w_alu_nonempty;
  logic          w_ls_nonempty;
  logic          w_grant_alu;
  logic          w_grant_ls;

  logic          r_done;
  cdb_entry_t    r_cdb;

  assign w_alu_in = '{rob_index: in_alu_rob_index, value: in_alu_value,
                      set_nzcv: in_alu_set_nzcv, nzcv: in_alu_nzcv};
  assign w_ls_in  = '{rob_index: in_ls_rob_index, value: in_ls_value,
                      set_nzcv: in_ls_set_nzcv, nzcv: in_ls_nzcv};

  // Ready looks only at the registered count so a same-cycle pop never frees a slot.
  assign out_alu_ready = (w_alu_count < DEPTH_C);
  assign out_ls_ready  = (w_ls_count < DEPTH_C);

  assign w_alu_push = in_alu_valid & out_alu_ready & ~in_mispred;
  assign w_ls_push  = in_ls_valid & out_ls_ready & ~in_mispred;

  assign w_alu_nonempty = (w_alu_count != '0);
  assign w_ls_nonempty  = (w_ls_count != '0);

`ifdef CDB_RR_EN
  grant_e r_last_grant;

  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_ls  = 1'b0;
    if (w_alu_nonempty && w_ls_nonempty) begin
      if (r_last_grant == GRANT_LS) w_grant_alu = 1'b1;
      else                          w_grant_ls  = 1'b1;
    end else begin
      w_grant_alu = w_alu_nonempty;
      w_grant_ls  = w_ls_nonempty;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n)                       r_last_grant <= GRANT_LS;
    else if (!in_mispred && w_grant_alu) r_last_grant <= GRANT_ALU;
    else if (!in_mispred && w_grant_ls)  r_last_grant <= GRANT_LS;
  end
`else
  always_comb begin
    w_grant_ls  = w_ls_nonempty;
    w_grant_alu = w_alu_nonempty & ~w_ls_nonempty;
  end
`endif

  assign w_alu_pop = w_grant_alu & ~in_mispred;
  assign w_ls_pop  = w_grant_ls & ~in_mispred;

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .i_push   (w_alu_push),
    .i_pop    (w_alu_pop),
    .i_flush  (in_mispred),
    .i_data   (w_alu_in),
    .o_head   (w_alu_head),
    .o_count  (w_alu_count)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_ls_fifo (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .i_push   (w_ls_push),
    .i_pop    (w_ls_pop),
    .i_flush  (in_mispred),
    .i_data   (w_ls_in),
    .o_head   (w_ls_head),
    .o_count  (w_ls_count)
  );

  // Broadcast register: data holds its last value whenever nothing is granted.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_done <= 1'b0;
      r_cdb  <= '0;
    end else if (in_mispred) begin
      r_done <= 1'b0;
    end else if (w_grant_ls) begin
      r_done <= 1'b1;
      r_cdb  <= w_ls_head;
    end else if (w_grant_alu) begin
      r_done <= 1'b1;
      r_cdb  <= w_alu_head;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign out_cdb_done     = r_done;
  assign out_cdb_index    = r_cdb.rob_index;
  assign out_cdb_value    = r_cdb.value;
  assign out_cdb_set_nzcv = r_cdb.set_nzcv;
  assign out_cdb_nzcv     = r_cdb.nzcv;

endmodule
